// File: rtl/retime_pkg.sv
// Shared lane definitions for the four-lane result re-alignment path.
package retime_pkg;
  localparam int NUM_LANES = 4;
  localparam int DATAWIDTH = 16;
  localparam int LANE_W    = DATAWIDTH + 1;

  typedef enum logic [1:0] {LANE_A, LANE_B, LANE_C, LANE_D} lane_e;
  typedef logic [LANE_W-1:0] lane_t;
endpackage

// File: rtl/lane_fifo.sv
// One lane buffer: circular memory with first-word fall-through head.
module lane_fifo #(
  parameter  int W      = 17,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    wdata,
  output logic [W-1:0]    head,
  output logic [ADDR_W:0] count,
  output logic            empty,
  output logic            drop
);
  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              full, wr_en, rd_en;

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full lane still accepts.
  assign wr_en = push & (~full | rd_en);
  assign drop  = push & full & ~rd_en;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/norm_result_collector.sv
// Re-aligns four independently-timed lane results into one valid/ready vector.
module norm_result_collector
  import retime_pkg::*;
#(
  parameter  int DATAWIDTH = 16,
  parameter  int DEPTH     = 8,
  localparam int LANE_W    = DATAWIDTH + 1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid_A,
  input  logic                      i_valid_B,
  input  logic                      i_valid_C,
  input  logic                      i_valid_D,
  input  logic [LANE_W-1:0]         i_data_A,
  input  logic [LANE_W-1:0]         i_data_B,
  input  logic [LANE_W-1:0]         i_data_C,
  input  logic [LANE_W-1:0]         i_data_D,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [4*LANE_W-1:0]       o_data,
  output logic [ADDR_W:0]           o_level,
  output logic [3:0]                o_overflow
);
  logic [NUM_LANES-1:0]             lane_v, lane_empty, lane_drop;
  logic [NUM_LANES-1:0][LANE_W-1:0] lane_d, lane_head;
  logic [NUM_LANES-1:0][ADDR_W:0]   lane_cnt;
  logic                             pop;

  assign lane_v[LANE_A] = i_valid_A;
  assign lane_v[LANE_B] = i_valid_B;
  assign lane_v[LANE_C] = i_valid_C;
  assign lane_v[LANE_D] = i_valid_D;
  assign lane_d[LANE_A] = i_data_A;
  assign lane_d[LANE_B] = i_data_B;
  assign lane_d[LANE_C] = i_data_C;
  assign lane_d[LANE_D] = i_data_D;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_fifo #(.W(LANE_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (lane_v[g]),
      .pop   (pop),
      .wdata (lane_d[g]),
      .head  (lane_head[g]),
      .count (lane_cnt[g]),
      .empty (lane_empty[g]),
      .drop  (lane_drop[g])
    );
  end

  assign o_valid = ~|lane_empty;
  assign pop     = o_valid & i_ready;
  assign o_data  = o_valid ? lane_head : '0;

  // Complete vectors are bounded by the shortest lane.
  always_comb begin
    o_level = lane_cnt[0];
    for (int i = 1; i < NUM_LANES; i++)
      if (lane_cnt[i] < o_level) o_level = lane_cnt[i];
  end

  always_ff @(posedge clk) begin
    if (rst) o_overflow <= '0;
    else     o_overflow <= o_overflow | lane_drop;
  end
endmodule

// File: tb/tb_norm_result_collector.sv
// Randomised and directed scoreboard bench for norm_result_collector.
module tb_norm_result_collector;
  import retime_pkg::*;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [3:0]          v = '0;
  lane_t               d [4];
  logic                ready = 1'b0;
  logic                o_valid;
  logic [4*LANE_W-1:0] o_data;
  logic [3:0]          o_level;
  logic [3:0]          o_overflow;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  // Reference model: per-lane occupancy, per-lane data not yet matched,
  // and the queue of expected assembled vectors.
  int                  mcnt [4];
  lane_t               lq   [4][$];
  logic [4*LANE_W-1:0] exp_q[$];
  logic [3:0]          mov = '0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 4; i++) begin d[i] = '0; mcnt[i] = 0; end

  norm_result_collector dut (
    .clk(clk), .rst(rst),
    .i_valid_A(v[0]), .i_valid_B(v[1]), .i_valid_C(v[2]), .i_valid_D(v[3]),
    .i_data_A(d[0]), .i_data_B(d[1]), .i_data_C(d[2]), .i_data_D(d[3]),
    .o_valid(o_valid), .i_ready(ready), .o_data(o_data),
    .o_level(o_level), .o_overflow(o_overflow)
  );

  function automatic bit all_nonempty();
    return mcnt[0] > 0 && mcnt[1] > 0 && mcnt[2] > 0 && mcnt[3] > 0;
  endfunction

  always @(posedge clk) begin
    bit pop;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin mcnt[i] = 0; lq[i].delete(); end
      exp_q.delete();
      mov = '0;
    end else begin
      pop = all_nonempty() && ready;
      for (int i = 0; i < 4; i++) begin
        if (pop) mcnt[i]--;
        if (v[i]) begin
          if (mcnt[i] < DEPTH) begin mcnt[i]++; lq[i].push_back(d[i]); end
          else mov[i] = 1'b1;
        end
      end
      while (lq[0].size() > 0 && lq[1].size() > 0 && lq[2].size() > 0 && lq[3].size() > 0)
        exp_q.push_back({lq[3].pop_front(), lq[2].pop_front(), lq[1].pop_front(), lq[0].pop_front()});
    end
  end

  task automatic chk(string name, logic [4*LANE_W-1:0] act, logic [4*LANE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on a handshake.
  always @(negedge clk) begin
    int lvl;
    if (mon_en) begin
      lvl = mcnt[0];
      for (int i = 1; i < 4; i++) if (mcnt[i] < lvl) lvl = mcnt[i];
      chk("o_valid", {67'b0, o_valid}, {67'b0, all_nonempty()});
      chk("o_level", {64'b0, o_level}, 68'(lvl));
      chk("o_overflow", {64'b0, o_overflow}, {64'b0, mov});
      if (all_nonempty()) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL scoreboard_empty actual=valid required=queued_vector at %0t", $time);
        end else begin
          chk("o_data", o_data, exp_q[0]);
          if (ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("o_data_idle", o_data, '0);
      end
    end
  end

  task automatic step(logic [3:0] vv, lane_t a, lane_t b, lane_t c, lane_t e, logic r);
    v = vv; d[0] = a; d[1] = b; d[2] = c; d[3] = e; ready = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n, logic r);
    for (int i = 0; i < n; i++) step(4'h0, '0, '0, '0, '0, r);
  endtask

  // One reset cycle with a push attempt that must be ignored.
  task automatic do_reset();
    rst = 1'b1;
    step(4'hF, 17'h1DEAD, 17'h1BEEF, 17'h0CAFE, 17'h0F00D, 1'b1);
    rst = 1'b0;
  endtask

  task automatic aligned(int k, logic r);
    step(4'hF, lane_t'(16'h1000 + k), lane_t'(16'h2000 + k),
         lane_t'(16'h3000 + k), lane_t'(16'h4000 + k), r);
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;
    idle(2, 1'b0);
    rst = 1'b0;
    idle(1, 1'b1);

    // Aligned push.
    step(4'hF, 17'h00100, 17'h00200, 17'h00300, 17'h00400, 1'b1);
    idle(3, 1'b1);

    // Skewed arrival.
    step(4'h1, 17'h00011, '0, '0, '0, 1'b1);
    step(4'h2, '0, 17'h00022, '0, '0, 1'b1);
    step(4'h4, '0, '0, 17'h00033, '0, 1'b1);
    step(4'h8, '0, '0, '0, 17'h00044, 1'b1);
    idle(3, 1'b1);

    // Backpressure to full, then one more vector overflows every lane.
    for (int k = 0; k < 9; k++) aligned(k, 1'b0);
    idle(2, 1'b0);
    idle(10, 1'b1);

    // Full lanes with simultaneous pop and push.
    do_reset();
    for (int k = 0; k < 8; k++) aligned(k + 16, 1'b0);
    aligned(99, 1'b1);
    idle(10, 1'b1);

    // Reset mid-operation with lane C overflowed.
    do_reset();
    for (int k = 0; k < 3; k++) aligned(k + 32, 1'b0);
    for (int k = 0; k < 6; k++) step(4'h4, '0, '0, lane_t'(17'h0C00 + k), '0, 1'b0);
    idle(1, 1'b0);
    do_reset();
    aligned(77, 1'b1);
    idle(3, 1'b1);

    // Runaway lane A.
    do_reset();
    for (int k = 0; k < 9; k++) step(4'h1, lane_t'(17'h0A00 + k), '0, '0, '0, 1'b0);
    step(4'hE, '0, 17'h0B00, 17'h0C00, 17'h0D00, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      step(4'($urandom), lane_t'($urandom), lane_t'($urandom), lane_t'($urandom),
           lane_t'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
    idle(12, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
